// File: rtl/hamming_tx.sv
// hamming_tx: Hamming(7,4) encoder with UART-style serialiser (start, a1..a7, stop).
// Optional error injection on the codeword when HAMMING_TX_ERR_INJECT_EN is defined.
module hamming_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data,
    input  logic       valid,
`ifdef HAMMING_TX_ERR_INJECT_EN
    input  logic [2:0] err_pos,
`endif
    output logic       ready,
    output logic       tx,
    output logic [7:1] code,
    output logic       busy,
    output logic       done
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic            tx_q, tx_d;
    logic [7:1]      code_q, code_d;
    logic            done_q, done_d;
    logic [7:1]      enc, flip;
    logic [7:0]      line;
    logic            expire;

    assign enc = {data[3], data[2], data[1], data[1] ^ data[2] ^ data[3],
                  data[0], data[0] ^ data[2] ^ data[3], data[0] ^ data[1] ^ data[3]};
`ifdef HAMMING_TX_ERR_INJECT_EN
    assign flip = 7'((8'd1 << err_pos) >> 1);
`else
    assign flip = '0;
`endif
    // bit 0 is the idle/stop level so index 0 after a7 naturally yields the stop bit
    assign line   = {code_q, 1'b1};
    assign expire = timer_q == LAST;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        code_d  = code_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (valid) begin
                state_d = START;
                code_d  = enc ^ flip;
                tx_d    = 1'b0;
                timer_d = '0;
                idx_d   = '0;
            end
        end else if (!expire) begin
            timer_d = timer_q + 1'b1;
        end else if (state_q == STOP) begin
            timer_d = '0;
            state_d = IDLE;
            done_d  = 1'b1;
        end else begin
            timer_d = '0;
            idx_d   = (idx_q == 3'd7) ? 3'd0 : idx_q + 3'd1;
            state_d = (idx_q == 3'd7) ? STOP : DATA;
            tx_d    = line[idx_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            code_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            code_q  <= code_d;
            done_q  <= done_d;
        end
    end

    assign ready = state_q == IDLE;
    assign busy  = state_q != IDLE;
    assign tx    = tx_q;
    assign code  = code_q;
    assign done  = done_q;
endmodule

// File: tb/tb_hamming_tx.sv
// tb_hamming_tx: directed checks of hamming_tx at CLKS_PER_BIT=4 and 1.
module tb_hamming_tx;
    logic       clk, rst;
    logic [3:0] data, data1;
    logic       valid, valid1;
    logic [2:0] err_pos;
    logic       ready, tx, busy, done;
    logic [7:1] code;
    logic       ready1, tx1, busy1, done1;
    logic [7:1] code1;
    int         n_chk = 0;
    int         n_pass = 0;

    hamming_tx #(.CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
`ifdef HAMMING_TX_ERR_INJECT_EN
        .err_pos(err_pos),
`endif
        .ready(ready), .tx(tx), .code(code), .busy(busy), .done(done)
    );

    hamming_tx #(.CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst(rst), .data(data1), .valid(valid1),
`ifdef HAMMING_TX_ERR_INJECT_EN
        .err_pos(3'd0),
`endif
        .ready(ready1), .tx(tx1), .code(code1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // serial bit expected during bit slot i: start, a1..a7, stop
    function automatic logic txbit(input logic [7:1] c, input int i);
        return (i == 0) ? 1'b0 : (i == 8) ? 1'b1 : c[i];
    endfunction

    // Call at a negedge with u4 ready; returns at the negedge of the done cycle.
    task automatic frame4(input logic [3:0] d, input logic [7:1] exp, input bit poke);
        int dones = 0;
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("code_load", code, exp);
        chk("busy_load", busy, 1'b1);
        for (int n = 0; n < 36; n++) begin
            chk($sformatf("tx_c%0d", n), tx, txbit(exp, n / 4));
            dones += done;
            if (poke && n == 10) begin
                data  = 4'b0110;
                valid = 1'b1;
            end
            if (poke && n == 11) valid = 1'b0;
            if (poke && n == 20) chk("code_hold", code, exp);
            @(negedge clk);
        end
        chk("done_early", dones, 0);
        chk("done_pulse", done, 1'b1);
        chk("ready_back", ready, 1'b1);
        chk("tx_idle", tx, 1'b1);
        chk("code_end", code, exp);
    endtask

    initial begin
        bit seen;
        logic [2:0] syn;
        rst = 1'b1; valid = 1'b0; data = '0; valid1 = 1'b0; data1 = '0; err_pos = '0;
        #2;
        chk("rst_tx", tx, 1'b1);
        chk("rst_code", code, 7'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx1", tx1, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frame4(4'b1011, 7'b1010101, 1'b0);

        // back-to-back with valid held high
        data  = 4'b0000;
        valid = 1'b1;
        @(negedge clk);
        data = 4'b1111;
        chk("b2b_code0", code, 7'b0000000);
        repeat (35) @(negedge clk);
        chk("b2b_tx_stop", tx, 1'b1);
        chk("b2b_nodone", done, 1'b0);
        @(negedge clk);
        chk("b2b_done", done, 1'b1);
        chk("b2b_code0_end", code, 7'b0000000);
        @(negedge clk);
        valid = 1'b0;
        chk("b2b_start", tx, 1'b0);
        chk("b2b_code1", code, 7'b1111111);
        chk("b2b_busy", busy, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk("b2b_done2", seen, 1'b1);

        frame4(4'b0011, 7'b0011110, 1'b1);

        // reset in mid-frame
        data  = 4'b1011;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1'b1);
        chk("mid_rst_code", code, 7'd0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_ready", ready, 1'b1);
        @(negedge clk);
        chk("mid_rst_done2", done, 1'b0);
        rst = 1'b0;
        frame4(4'b0110, 7'b0110011, 1'b0);

`ifdef HAMMING_TX_ERR_INJECT_EN
        err_pos = 3'd5;
        frame4(4'b1011, 7'b1000101, 1'b0);
        syn = {code[4] ^ code[5] ^ code[6] ^ code[7],
               code[2] ^ code[3] ^ code[6] ^ code[7],
               code[1] ^ code[3] ^ code[5] ^ code[7]};
        chk("syndrome", syn, 3'd5);
        err_pos = 3'd0;
`endif

        // one clock per bit
        data1  = 4'b1011;
        valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        chk("c1_code", code1, 7'b1010101);
        for (int n = 0; n < 9; n++) begin
            chk($sformatf("c1_tx%0d", n), tx1, txbit(7'b1010101, n));
            chk($sformatf("c1_nodone%0d", n), done1, 1'b0);
            @(negedge clk);
        end
        chk("c1_done", done1, 1'b1);
        chk("c1_ready", ready1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
